// File: rtl/board_io_pkg.sv
// board_io_pkg: register offsets, CTRL bit positions and the
// 7-segment glyph table shared by the board I/O controller.
package board_io_pkg;

  localparam logic [2:0] REG_HEX  = 3'd0;
  localparam logic [2:0] REG_LEDR = 3'd1;
  localparam logic [2:0] REG_KEY  = 3'd2;
  localparam logic [2:0] REG_EDGE = 3'd3;
  localparam logic [2:0] REG_SW   = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;

  localparam int CTRL_BLANK = 0;
  localparam int CTRL_BLINK = 1;

  // Active-low segments, bit order g..a; index 15 first.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0e, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7(input logic [3:0] v);
    return GLYPHS[v];
  endfunction

endpackage

// File: rtl/board_io_ctrl_debounce.sv
// io_debounce: 2-flop synchroniser plus per-bit debounce counter.
// Ports: pins (raw async), level (accepted), rise (level 0->1 this edge).
module io_debounce #(
  parameter int WIDTH = 1,
  parameter int DEB_CYCLES = 50000,
  parameter logic [WIDTH-1:0] SYNC_INIT = '0,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] flip;
  logic [CW-1:0]    cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= SYNC_INIT;
      s2 <= SYNC_INIT;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  end

  assign cur = INVERT ? ~s2 : s2;

  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++)
      flip[i] = (cur[i] != level[i]) && (cnt[i] == LAST);
  end

  // A flip always moves level toward cur, so a rise is a flip to 1.
  assign rise = flip & cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      level <= level ^ flip;
      for (int i = 0; i < WIDTH; i++) begin
        if (cur[i] == level[i] || flip[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: memory-mapped key/switch/LED/7-seg controller.
// Ports: clk/reset, addr/wr_en/wr_data/rd_en/rd_data bus, key/sw pins, led/hex drive.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int NUM_KEYS     = 4,
  parameter int NUM_SW       = 10,
  parameter int NUM_LEDR     = 10,
  parameter int NUM_HEX      = 4,
  parameter int DEB_CYCLES   = 50000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            addr,
  input  logic                  wr_en,
  input  logic [DBITS-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [DBITS-1:0]      rd_data,
  input  logic [NUM_KEYS-1:0]   key_in,
  input  logic [NUM_SW-1:0]     sw_in,
  output logic [NUM_LEDR-1:0]   ledr_out,
  output logic [7*NUM_HEX-1:0]  hex_out
);

  localparam int BW =
    (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [4*NUM_HEX-1:0] hex_q;
  logic [NUM_LEDR-1:0]  ledr_q;
  logic [1:0]           ctrl_q;
  logic [NUM_KEYS-1:0]  edge_q;
  logic [NUM_KEYS-1:0]  edge_clr;
  logic [NUM_KEYS-1:0]  key_lvl;
  logic [NUM_KEYS-1:0]  key_rise;
  logic [NUM_SW-1:0]    sw_lvl;
  logic [NUM_SW-1:0]    unused_sw_rise;
  logic                 unused_wr;
  logic [BW-1:0]        blink_cnt;
  logic                 phase_q;
  logic [DBITS-1:0]     rd_mux;
  logic [7*NUM_HEX-1:0] disp;

  assign unused_wr = ^wr_data;

  io_debounce #(
    .WIDTH(NUM_KEYS),
    .DEB_CYCLES(DEB_CYCLES),
    .SYNC_INIT({NUM_KEYS{1'b1}}),
    .INVERT(1'b1)
  ) u_keys (
    .clk(clk),
    .reset(reset),
    .pins(key_in),
    .level(key_lvl),
    .rise(key_rise)
  );

  io_debounce #(
    .WIDTH(NUM_SW),
    .DEB_CYCLES(DEB_CYCLES),
    .SYNC_INIT('0),
    .INVERT(1'b0)
  ) u_sw (
    .clk(clk),
    .reset(reset),
    .pins(sw_in),
    .level(sw_lvl),
    .rise(unused_sw_rise)
  );

  assign edge_clr = (wr_en && addr == REG_EDGE) ?
    wr_data[NUM_KEYS-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (addr == REG_HEX):  rd_mux[4*NUM_HEX-1:0] = hex_q;
      (addr == REG_LEDR): rd_mux[NUM_LEDR-1:0]  = ledr_q;
      (addr == REG_KEY):  rd_mux[NUM_KEYS-1:0]  = key_lvl;
      (addr == REG_EDGE): rd_mux[NUM_KEYS-1:0]  = edge_q;
      (addr == REG_SW):   rd_mux[NUM_SW-1:0]    = sw_lvl;
      (addr == REG_CTRL): rd_mux[1:0]           = ctrl_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q   <= '0;
      ledr_q  <= '0;
      ctrl_q  <= '0;
      edge_q  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && addr == REG_HEX)
        hex_q <= wr_data[4*NUM_HEX-1:0];
      if (wr_en && addr == REG_LEDR)
        ledr_q <= wr_data[NUM_LEDR-1:0];
      if (wr_en && addr == REG_CTRL)
        ctrl_q <= wr_data[1:0];
      // Set has priority over a same-cycle clear.
      edge_q <= (edge_q & ~edge_clr) | key_rise;
      if (rd_en)
        rd_data <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !ctrl_q[CTRL_BLINK]) begin
      blink_cnt <= '0;
      phase_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_q   <= ~phase_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_comb begin
    disp = '1;
    for (int i = 0; i < NUM_HEX; i++)
      disp[7*i +: 7] = seg7(hex_q[4*i +: 4]);
    if (ctrl_q[CTRL_BLANK] ||
        (ctrl_q[CTRL_BLINK] && phase_q))
      disp = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ledr_out <= '0;
      hex_out  <= {NUM_HEX{7'b1000000}};
    end else begin
      ledr_out <= ledr_q;
      hex_out  <= disp;
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: randomized self-checking bench for board_io_ctrl
// against a behavioural register/debounce/display model.
module tb_board_io_ctrl;

  localparam int DEB   = 8;
  localparam int BLINK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [3:0]  key_in;
  logic [9:0]  sw_in;
  logic [9:0]  ledr_out;
  logic [27:0] hex_out;

  int checks = 0;
  int failures = 0;

  board_io_ctrl #(
    .DBITS(32), .NUM_KEYS(4), .NUM_SW(10), .NUM_LEDR(10),
    .NUM_HEX(4), .DEB_CYCLES(DEB), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .key_in(key_in), .sw_in(sw_in), .ledr_out(ledr_out),
    .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [1:0]  m_ctrl;
  logic [3:0]  m_edge;
  logic [3:0]  m_key;
  logic [9:0]  m_sw;
  int          m_n;
  logic [13:0] hist [0:DEB];
  int          since [14];
  logic [31:0] exp_rd;
  logic [9:0]  exp_ledr;
  logic [27:0] exp_hex;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79;
      4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12;
      4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10;
      4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21;
      4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] glyphs_of(input logic [15:0] v);
    logic [27:0] d;
    for (int i = 0; i < 4; i++) d[7*i +: 7] = glyph(v[4*i +: 4]);
    return d;
  endfunction

  function automatic logic [27:0] model_disp();
    logic [27:0] d;
    d = glyphs_of(m_hex);
    if (m_ctrl[0] || (m_ctrl[1] && ((m_n / BLINK) % 2 == 1)))
      d = '1;
    return d;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'h0, m_hex};
      3'd1: return {22'h0, m_ledr};
      3'd2: return {28'h0, m_key};
      3'd3: return {28'h0, m_edge};
      3'd4: return {22'h0, m_sw};
      3'd5: return {30'h0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  // A level flips once the last DEB synchronised samples all disagree
  // with it and at least DEB edges have passed since its last flip.
  always @(posedge clk) begin
    logic [13:0] cur, flp, nl;
    logic [3:0]  clr;
    if (reset) begin
      m_hex = 0; m_ledr = 0; m_ctrl = 0; m_edge = 0;
      m_key = 0; m_sw = 0; m_n = 0;
      exp_rd = 0; exp_ledr = 0; exp_hex = {4{7'h40}};
      for (int k = 0; k <= DEB; k++) hist[k] = 14'h0;
      for (int b = 0; b < 14; b++) since[b] = 0;
    end else begin
      exp_ledr = m_ledr;
      exp_hex  = model_disp();
      if (rd_en) exp_rd = model_read(addr);
      cur = {m_sw, m_key};
      flp = '1;
      for (int k = 1; k <= DEB; k++) flp &= hist[k] ^ cur;
      for (int b = 0; b < 14; b++) begin
        since[b]++;
        if (since[b] < DEB) flp[b] = 1'b0;
        if (flp[b]) since[b] = 0;
      end
      nl  = cur ^ flp;
      clr = (wr_en && addr == 3'd3) ? wr_data[3:0] : 4'h0;
      m_edge = (m_edge & ~clr) | (nl[3:0] & ~cur[3:0]);
      m_key = nl[3:0];
      m_sw  = nl[13:4];
      if (m_ctrl[1]) m_n++; else m_n = 0;
      if (wr_en) begin
        if (addr == 3'd0) m_hex  = wr_data[15:0];
        if (addr == 3'd1) m_ledr = wr_data[9:0];
        if (addr == 3'd5) m_ctrl = wr_data[1:0];
      end
      for (int k = DEB; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = {sw_in, ~key_in};
    end
  end

  // ---------------- bus helpers (called at negedge) ----------------
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ledr_out !== 10'h0) begin
      failures++;
      $display("FAIL reset_ledr got=%h want=0", ledr_out);
    end
    checks++;
    if (hex_out !== {4{7'b1000000}}) begin
      failures++;
      $display("FAIL reset_hex got=%h want=%h", hex_out, {4{7'b1000000}});
    end
    for (int a = 0; a < 8; a++) begin
      do_read(3'(a), d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_read%0d got=%h want=0", a, d);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    do_write(3'd0, 32'hFFFF_1234);
    do_write(3'd1, 32'hFFFF_F2AA);
    @(negedge clk);
    checks++;
    if (hex_out !== {glyph(1), glyph(2), glyph(3), glyph(4)}) begin
      failures++;
      $display("FAIL hex_1234 got=%h want=%h", hex_out,
               {glyph(1), glyph(2), glyph(3), glyph(4)});
    end
    checks++;
    if (ledr_out !== 10'h2AA) begin
      failures++;
      $display("FAIL ledr_2aa got=%h want=2aa", ledr_out);
    end
    do_read(3'd0, d);
    checks++;
    if (d !== 32'h1234) begin
      failures++;
      $display("FAIL read_hex got=%h want=1234", d);
    end
    do_read(3'd1, d);
    checks++;
    if (d !== 32'h2AA) begin
      failures++;
      $display("FAIL read_ledr got=%h want=2aa", d);
    end
    for (int i = 0; i < 6; i++) begin
      do_write(3'd0, $urandom);
      do_write(3'd1, $urandom);
      @(negedge clk);
      checks++;
      if (hex_out !== exp_hex || ledr_out !== exp_ledr) begin
        failures++;
        $display("FAIL rand_out hex=%h/%h led=%h/%h",
                 hex_out, exp_hex, ledr_out, exp_ledr);
      end
      do_read(3'($urandom_range(0, 1)), d);
      checks++;
      if (d !== exp_rd) begin
        failures++;
        $display("FAIL rand_read got=%h want=%h", d, exp_rd);
      end
    end
    // Write to a read-only offset and simultaneous read/write.
    do_write(3'd2, 32'hF);
    rd_en = 1'b1; wr_en = 1'b1; addr = 3'd1; wr_data = 32'h155;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    checks++;
    if (rd_data !== exp_rd || rd_data === 32'h155) begin
      failures++;
      $display("FAIL rw_same got=%h want=%h", rd_data, exp_rd);
    end
    do_read(3'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL ro_write got=%h want=0", d);
    end
  endtask

  task automatic test_key_debounce();
    logic [31:0] d;
    int first;
    key_in[2] = 1'b0;
    repeat (5) @(negedge clk);
    key_in[2] = 1'b1;
    rd_en = 1'b1; addr = 3'd2;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (rd_data !== 32'h0 || rd_data !== exp_rd) begin
        failures++;
        $display("FAIL glitch k=%0d got=%h want=0", k, rd_data);
      end
    end
    key_in[2] = 1'b0;
    first = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checks++;
      if (rd_data !== exp_rd) begin
        failures++;
        $display("FAIL deb_level k=%0d got=%h want=%h", k, rd_data, exp_rd);
      end
      if (first < 0 && rd_data === 32'h4) first = k;
    end
    rd_en = 1'b0;
    checks++;
    if (first !== DEB + 2) begin
      failures++;
      $display("FAIL deb_latency got=%0d want=%0d", first, DEB + 2);
    end
    do_read(3'd3, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL edge_set got=%h want=4", d);
    end
    do_write(3'd3, 32'h4);
    do_read(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL edge_w1c got=%h want=0", d);
    end
    key_in[2] = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    do_read(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL edge_release got=%h want=0", d);
    end
  endtask

  task automatic test_edge_collision();
    logic [31:0] d;
    do_write(3'd3, 32'hF);
    key_in[0] = 1'b0;
    repeat (DEB + 1) @(negedge clk);
    wr_en = 1'b1; addr = 3'd3; wr_data = 32'h1;
    @(negedge clk);
    wr_en = 1'b0;
    do_read(3'd3, d);
    checks++;
    if (d !== 32'h1 || d !== exp_rd) begin
      failures++;
      $display("FAIL set_wins got=%h want=1", d);
    end
    do_write(3'd3, 32'h1);
    do_read(3'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL clear_after got=%h want=0", d);
    end
    key_in[0] = 1'b1;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic test_blink();
    logic [27:0] g, want;
    do_write(3'd0, 32'hA5C9);
    @(negedge clk);
    g = glyphs_of(16'hA5C9);
    do_write(3'd5, 32'h2);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      want = (((j - 1) / BLINK) % 2 == 1) ? '1 : g;
      checks++;
      if (hex_out !== want || hex_out !== exp_hex) begin
        failures++;
        $display("FAIL blink j=%0d got=%h want=%h", j, hex_out, want);
      end
    end
    do_write(3'd5, 32'h3);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (hex_out !== 28'hFFFFFFF) begin
        failures++;
        $display("FAIL blank j=%0d got=%h want=fffffff", j, hex_out);
      end
      @(negedge clk);
    end
    do_write(3'd5, 32'h0);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (hex_out !== g) begin
        failures++;
        $display("FAIL steady j=%0d got=%h want=%h", j, hex_out, g);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_reset();
    int first;
    sw_in = 10'h3FF;
    repeat (DEB - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_en = 1'b1; addr = 3'd4;
    first = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      checks++;
      if (rd_data !== exp_rd) begin
        failures++;
        $display("FAIL sw_level k=%0d got=%h want=%h", k, rd_data, exp_rd);
      end
      if (first < 0 && rd_data === 32'h3FF) first = k;
    end
    rd_en = 1'b0;
    checks++;
    if (first !== DEB + 3) begin
      failures++;
      $display("FAIL sw_reset_latency got=%0d want=%0d", first, DEB + 3);
    end
  endtask

  task automatic test_random();
    int op;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 11) == 0)
        key_in[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 11) == 0)
        sw_in[$urandom_range(0, 9)] ^= 1'b1;
      op = $urandom_range(0, 4);
      addr    = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      wr_en   = (op == 0 || op == 2);
      rd_en   = (op == 1 || op == 2);
      @(negedge clk);
      checks++;
      if (rd_data !== exp_rd || hex_out !== exp_hex ||
          ledr_out !== exp_ledr) begin
        failures++;
        $display("FAIL random c=%0d rd=%h/%h hex=%h/%h led=%h/%h", c,
                 rd_data, exp_rd, hex_out, exp_hex, ledr_out, exp_ledr);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = 3'd0; wr_en = 1'b0; wr_data = 32'h0;
    rd_en = 1'b0; key_in = 4'hF; sw_in = 10'h0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_key_debounce();
    test_edge_collision();
    test_blink();
    test_sw_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
